// File: rtl/scroll_pkg.sv
// Shared constants for the scrolling 7-segment display: active-low gfedcba
// segment patterns, controller state encoding and display geometry.
package scroll_pkg;

    localparam int N_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_V     = 7'b1000001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_S     = 7'b0010010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_SCROLL = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    function automatic logic is_active(input state_t s);
        return (s == ST_SCROLL) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/scroll_tick.sv
// Scroll-step divider: one-cycle tick every CLK_DIV clocks, counter restarts on clear.
// Latency: tick is combinational from the count; first tick CLK_DIV-1 cycles after clear drops.
module scroll_tick #(
    parameter int CLK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scroll_ctrl.sv
// Message scroller: buffers up to MSG_MAX characters, then shifts them across s1..s6 one per tick.
// Writes accepted only in IDLE (wr_ready); SCROLL_REPEAT_EN makes the message loop instead of one-shot.
module scroll_ctrl #(
    parameter int CLK_DIV = 5_000_000,
    parameter int MSG_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_char,
    input  logic       wr_last,
    output logic [6:0] s1,
    output logic [6:0] s2,
    output logic [6:0] s3,
    output logic [6:0] s4,
    output logic [6:0] s5,
    output logic [6:0] s6,
    output logic       busy
);

    import scroll_pkg::*;

    localparam int PW = $clog2(MSG_MAX);
    localparam int LW = PW + 1;

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] len;
    logic [PW-1:0] rd_ptr;
    logic [2:0]    flush_cnt;
    logic          rdy_q;
    logic [6:0]    msg_buf [MSG_MAX];
    logic [6:0]    disp    [N_DIGITS];

    logic          tick;
    logic          tick_clr;
    logic          accept;
    logic          last_wr;
    logic          last_rd;
    logic          flush_done;
    logic          blank_all;
    logic          shift;
    logic [6:0]    shift_val;

    // Divider only runs while characters are moving, so SCROLL entry starts a full period.
    assign tick_clr = !is_active(state);

    scroll_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(tick_clr),
        .tick (tick)
    );

    assign accept     = wr_valid && rdy_q && (state == ST_IDLE);
    assign last_wr    = wr_last || (wr_ptr == LW'(MSG_MAX - 1));
    assign last_rd    = (rd_ptr == PW'(len - LW'(1)));
    assign flush_done = (flush_cnt == 3'd5);

    assign blank_all  = clr || !is_active(state) || !en;
    assign shift      = tick && !blank_all;
    assign shift_val  = (state == ST_SCROLL) ? msg_buf[rd_ptr] : SEG_BLANK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && last_wr) begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (en) begin
                        state_nx = ST_SCROLL;
                    end
                end
                ST_SCROLL: begin
                    if (!en) begin
                        state_nx = ST_ARMED;
                    end else if (tick && last_rd) begin
                        state_nx = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!en) begin
                        state_nx = ST_ARMED;
                    end else if (tick && flush_done) begin
`ifdef SCROLL_REPEAT_EN
                        state_nx = ST_SCROLL;
`else
                        state_nx = ST_IDLE;
`endif
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = is_active(state);
        wr_ready = rdy_q;
    end

    // Registered so wr_ready stays low through reset and rises on the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= (state_nx == ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            len       <= '0;
            rd_ptr    <= '0;
            flush_cnt <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            len    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + LW'(1);
                        len    <= wr_ptr + LW'(1);
                    end
                end
                ST_ARMED: begin
                    if (en) begin
                        rd_ptr <= '0;
                    end
                end
                ST_SCROLL: begin
                    if (en && tick) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        if (last_rd) begin
                            flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (en && tick) begin
                        flush_cnt <= flush_cnt + 3'd1;
                        if (flush_done) begin
`ifdef SCROLL_REPEAT_EN
                            rd_ptr <= '0;
`else
                            wr_ptr <= '0;
                            len    <= '0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer contents deliberately survive reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (accept && !clr) begin
            msg_buf[wr_ptr[PW-1:0]] <= wr_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                disp[i] <= SEG_BLANK;
            end
        end else if (blank_all) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                disp[i] <= SEG_BLANK;
            end
        end else if (shift) begin
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                disp[i] <= disp[i-1];
            end
            disp[0] <= shift_val;
        end
    end

    assign s1 = disp[0];
    assign s2 = disp[1];
    assign s3 = disp[2];
    assign s4 = disp[3];
    assign s5 = disp[4];
    assign s6 = disp[5];

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl with CLK_DIV=4; expectations follow SCROLL_REPEAT_EN.
module tb_scroll_ctrl;

    import scroll_pkg::*;

    localparam int DIV  = 4;
    localparam int MAXC = 16;
`ifdef SCROLL_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif
    localparam logic [41:0] ALL_BLANK = {6{SEG_BLANK}};

    logic       clk = 1'b0;
    logic       rst, en, clr, wr_valid, wr_ready, wr_last, busy;
    logic [6:0] wr_char, s1, s2, s3, s4, s5, s6;

    always #5 clk = ~clk;

    scroll_ctrl #(
        .CLK_DIV(DIV),
        .MSG_MAX(MAXC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_char (wr_char),
        .wr_last (wr_last),
        .s1      (s1),
        .s2      (s2),
        .s3      (s3),
        .s4      (s4),
        .s5      (s5),
        .s6      (s6),
        .busy    (busy)
    );

    typedef struct {
        int          cyc;
        logic [41:0] frame;
        logic        busy;
    } exp_t;

    typedef struct {
        logic       vld;
        logic [6:0] ch;
        logic       last;
        logic       en;
        logic       exp_rdy;
        logic       exp_busy;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    exp_t        q[$];
    vec_t        vecs[4];
    logic [6:0]  msg[MAXC];
    int          msg_len;
    logic [41:0] exp_frame;
    logic        exp_busy;
    logic [6:0]  letters[9] = '{SEG_I, SEG_L, SEG_O, SEG_V, SEG_E, SEG_C, SEG_A, SEG_R, SEG_S};

    function automatic logic [41:0] frame_now();
        return {s1, s2, s3, s4, s5, s6};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected display history: each tick shifts the next char into s1, then six blanks.
    task automatic push_scroll();
        logic [41:0] f;
        int          t;
        f = ALL_BLANK;
        t = 0;
        for (int p = 0; p < (REPEAT ? 2 : 1); p++) begin
            for (int k = 0; k < msg_len; k++) begin
                t += DIV;
                f = {msg[k], f[41:7]};
                q.push_back('{t, f, 1'b1});
            end
            if (p == 0) begin
                for (int j = 0; j < 6; j++) begin
                    t += DIV;
                    f = {SEG_BLANK, f[41:7]};
                    q.push_back('{t, f, (j < 5) ? 1'b1 : REPEAT});
                end
            end
        end
    endtask

    task automatic start_scroll();
        q.delete();
        en  = 1'b1;
        cyc = -1;
        step();
        exp_frame = ALL_BLANK;
        exp_busy  = 1'b1;
        chk("busy_start", busy, 1'b1);
        push_scroll();
    endtask

    task automatic watch(input int ncyc);
        exp_t e;
        repeat (ncyc) begin
            step();
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                exp_frame = e.frame;
                exp_busy  = e.busy;
            end
            chk($sformatf("frame@%0d", cyc), frame_now(), exp_frame);
            chk($sformatf("busy@%0d", cyc), busy, exp_busy);
        end
    endtask

    task automatic load_msg(input int n);
        msg_len = n;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_char  = msg[i];
            wr_last  = (i == n - 1);
            chk($sformatf("load_rdy%0d", i), wr_ready, 1'b1);
            step();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        en  = 1'b0;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, SEG_I, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, SEG_L, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, SEG_O, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, SEG_O, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; en = 1'b0; clr = 1'b0;
        wr_valid = 1'b0; wr_char = '0; wr_last = 1'b0; cyc = 0;
        #12;
        chk("rst_frame", frame_now(), ALL_BLANK);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdy", wr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_before_edge", wr_ready, 1'b0);
        step();
        chk("rdy_after_rst", wr_ready, 1'b1);

        // Two-char message; third write lands in ARMED and must be dropped.
        for (int i = 0; i < 4; i++) begin
            wr_valid = vecs[i].vld;
            wr_char  = vecs[i].ch;
            wr_last  = vecs[i].last;
            en       = vecs[i].en;
            chk($sformatf("vec%0d_rdy", i), wr_ready, vecs[i].exp_rdy);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_frame", i), frame_now(), ALL_BLANK);
            step();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        msg[0] = SEG_I; msg[1] = SEG_L;
        msg_len = 2;
        start_scroll();
        watch(40);
        if (!REPEAT) chk("oneshot_rdy", wr_ready, 1'b1);
        do_clr();

        // Full buffer without wr_last arms on the 16th write.
        for (int i = 0; i < MAXC; i++) msg[i] = letters[i % 9];
        msg_len = MAXC;
        for (int i = 0; i < MAXC; i++) begin
            wr_valid = 1'b1;
            wr_char  = msg[i];
            chk($sformatf("full_rdy%0d", i), wr_ready, 1'b1);
            step();
        end
        chk("full_17th_rdy", wr_ready, 1'b0);
        step();
        wr_valid = 1'b0;
        chk("full_busy", busy, 1'b0);
        chk("full_frame", frame_now(), ALL_BLANK);
        start_scroll();
        watch(4 * (MAXC + 6) + 4);
        do_clr();

        // Abort on a tick edge, then restart from buf[0]; clr during FLUSH.
        msg[0] = SEG_I; msg[1] = SEG_L; msg[2] = SEG_O; msg[3] = SEG_V; msg[4] = SEG_E;
        load_msg(5);
        start_scroll();
        watch(7);
        en = 1'b0;
        step();
        chk("abort_frame", frame_now(), ALL_BLANK);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdy", wr_ready, 1'b0);
        step();
        chk("armed_hold_frame", frame_now(), ALL_BLANK);
        start_scroll();
        watch(26);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_frame", frame_now(), ALL_BLANK);
        chk("clr_busy", busy, 1'b0);
        chk("clr_rdy", wr_ready, 1'b1);
        en = 1'b0;
        step();
        chk("clr_rdy_hold", wr_ready, 1'b1);

        // Asynchronous reset mid-scroll blanks outputs with no clock edge.
        msg[0] = SEG_C; msg[1] = SEG_A;
        load_msg(2);
        start_scroll();
        watch(5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_frame", frame_now(), ALL_BLANK);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rdy", wr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        step();
        chk("arst_rdy_rise", wr_ready, 1'b1);
        chk("arst_frame_after", frame_now(), ALL_BLANK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
